// File: rtl/alu_hs.sv
// alu_hs - parametrised ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (add/sub/logic/shift/cmp/pass/illegal) are computed
// combinationally from the operands and captured in the result registers at
// acceptance, so the result is presented one cycle later. MUL runs an
// iterative shift-add over WIDTH cycles and then writes the same registers.
//
// Ports
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   in_valid   operand/opcode valid
//   in_ready   block can accept an operation this cycle
//   OPCODE     operation select (4 bits)
//   OP1, OP2   operands (OP2 also carries the shift amount)
//   out_valid  result registers valid
//   out_ready  consumer takes the result this cycle
//   RESULT     result low word
//   RESULT_HI  MUL high word, 0 for every other op
//   FLAGS      {ERR, V, C, N, Z}

module alu_hs #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic [4:0]       FLAGS
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  // Everything the output side presents, written as one unit.
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [4:0]       flags;
  } res_t;

  state_t           state, state_nxt;
  res_t             res_q, alu_res, mul_res;
  logic             out_valid_q;

  // Multiplier: {acc_hi, mplier} forms the running 2*WIDTH product; the
  // multiplier bits are shifted out of the bottom as product bits shift in.
  logic [WIDTH-1:0] mcand, mplier, acc_hi;
  logic [WIDTH-1:0] acc_nxt, mpl_nxt;
  logic [WIDTH:0]   step_sum;
  logic [SHW-1:0]   cnt;

  logic             accept, is_mul, mul_done, wr_alu;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (OPCODE == OP_MUL);
  assign wr_alu   = accept && !is_mul;
  assign mul_done = (state == S_MUL) && (cnt == CNT_LAST);

  assign out_valid = out_valid_q;
  assign RESULT    = res_q.lo;
  assign RESULT_HI = res_q.hi;
  assign FLAGS     = res_q.flags;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_done)         state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new op may issue in the same cycle the consumer drains the old one.
  always_comb begin
    in_ready = (state == S_IDLE) && (!out_valid_q || out_ready);
  end

  // ------------------------------------------------- single-cycle datapath
  logic [SHW-1:0] sh;
  logic [WIDTH:0] sum, dif, shl, shr, sra;
  logic           v_add, v_sub, c, v, err, z;

  always_comb begin
    alu_res = '0;
    c       = 1'b0;
    v       = 1'b0;
    err     = 1'b0;
    sh      = OP2[SHW-1:0];
    sum     = {1'b0, OP1} + {1'b0, OP2};
    dif     = {1'b0, OP1} - {1'b0, OP2};
    // Shifts run one bit wider so the last bit shifted out lands in the
    // extra position; an amount of 0 leaves that position 0.
    shl     = {1'b0, OP1} << sh;
    shr     = {OP1, 1'b0} >> sh;
    sra     = $signed({OP1, 1'b0}) >>> sh;
    v_add   = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
    v_sub   = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (dif[WIDTH-1] != OP1[WIDTH-1]);

    case (OPCODE)
      OP_ADD:  begin alu_res.lo = sum[WIDTH-1:0]; c = sum[WIDTH]; v = v_add; end
      OP_SUB:  begin alu_res.lo = dif[WIDTH-1:0]; c = dif[WIDTH]; v = v_sub; end
      OP_AND:  alu_res.lo = OP1 & OP2;
      OP_OR:   alu_res.lo = OP1 | OP2;
      OP_XOR:  alu_res.lo = OP1 ^ OP2;
      OP_NOT:  alu_res.lo = ~OP1;
      OP_SHL:  begin alu_res.lo = shl[WIDTH-1:0]; c = shl[WIDTH]; end
      OP_SHR:  begin alu_res.lo = shr[WIDTH:1];   c = shr[0];     end
      OP_SRA:  begin alu_res.lo = sra[WIDTH:1];   c = sra[0];     end
      OP_MUL:  ;  // result comes from the iterative multiplier
      OP_CMP:  begin c = dif[WIDTH]; v = v_sub; end
      OP_PASS: alu_res.lo = OP2;
      default: err = 1'b1;
    endcase

    // CMP reports Z on the difference even though RESULT is forced to 0.
    z = !err && ((OPCODE == OP_CMP) ? (dif[WIDTH-1:0] == '0) : (alu_res.lo == '0));
    alu_res.flags = {err, v, c, !err && alu_res.lo[WIDTH-1], z};
  end

  // ---------------------------------------------------- multiplier step
  always_comb begin
    step_sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt  = step_sum[WIDTH:1];
    mpl_nxt  = {step_sum[0], mplier[WIDTH-1:1]};

    mul_res       = '0;
    mul_res.lo    = mpl_nxt;
    mul_res.hi    = acc_nxt;
    mul_res.flags = {3'b000, acc_nxt[WIDTH-1], ({acc_nxt, mpl_nxt} == '0)};
  end

  // ------------------------------------------------------ registers
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc_hi      <= '0;
      cnt         <= '0;
    end else begin
      // Result registers change only on a write, so they hold under
      // backpressure; a write in the drain cycle keeps out_valid high.
      if (wr_alu || mul_done)  out_valid_q <= 1'b1;
      else if (out_ready)      out_valid_q <= 1'b0;

      if (wr_alu)              res_q <= alu_res;
      else if (mul_done)       res_q <= mul_res;

      if (accept && is_mul) begin
        mcand  <= OP1;
        mplier <= OP2;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state == S_MUL) begin
        acc_hi <= acc_nxt;
        mplier <= mpl_nxt;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
module tb_alu_hs;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   OPCODE;
  logic [W-1:0] OP1, OP2, RESULT, RESULT_HI;
  logic [4:0]   FLAGS;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .out_valid(out_valid),
    .out_ready(out_ready), .RESULT(RESULT), .RESULT_HI(RESULT_HI), .FLAGS(FLAGS)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, r, h;
    logic [4:0]   f;
    string        nm;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic rules, using plain integers.
  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, b,
                                    output logic [W-1:0] r, h, output logic [4:0] f);
    int ia, ib, sa, sb, t, sh;
    logic c, v, z, n;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    sh = ib % 8;
    c = 1'b0; v = 1'b0; h = '0; t = 0; r = '0;
    case (op)
      0:  begin t = ia + ib; r = t[7:0]; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1:  begin t = ia - ib; r = t[7:0]; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a;
      6:  begin t = (ia << sh) & 255; r = t[7:0]; c = (sh != 0) && (((ia >> (8 - sh)) & 1) != 0); end
      7:  begin r = a >> sh; c = (sh != 0) && (((ia >> (sh - 1)) & 1) != 0); end
      8:  begin t = sa >>> sh; r = t[7:0]; c = (sh != 0) && (((ia >> (sh - 1)) & 1) != 0); end
      9:  begin t = ia * ib; r = t[7:0]; h = t[15:8]; end
      10: begin t = ia - ib; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
      11: r = b;
      default: ;
    endcase
    z = (op == 9) ? (t == 0) : (op == 10) ? (t[7:0] == 8'h00) : (r == '0);
    n = (op == 9) ? h[7] : r[7];
    f = (op >= 12) ? 5'b10000 : {1'b0, v, c, n, z};
  endfunction

  // Issue one op, wait for the result, check it, optionally stall the
  // consumer for a few cycles, then drain.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, b, input int stall,
                       input logic [W-1:0] er, eh, input logic [4:0] ef, input string nm);
    int guard;
    @(negedge clk);
    OPCODE = op; OP1 = a; OP2 = b; in_valid = 1'b1; out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk({nm, "_issue_timeout"}, 16'(guard < 50), 16'd1);
    @(negedge clk);  // accepted at the posedge in between
    in_valid = 1'b0; OP1 = ~a; OP2 = ~b;
    guard = 0;
    while (!out_valid && guard < 40) begin
      if (in_ready) begin n_fail++; $display("FAIL %s_busy: in_ready high during MUL", nm); end
      @(negedge clk); guard++;
    end
    chk({nm, "_latency"}, 16'(guard), (op == 4'd9) ? 16'(W) : 16'd0);
    chk({nm, "_res"}, 16'(RESULT), 16'(er));
    chk({nm, "_hi"}, 16'(RESULT_HI), 16'(eh));
    chk({nm, "_flags"}, 16'(FLAGS), 16'(ef));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({nm, "_hold"}, {out_valid, in_ready, 6'd0, RESULT}, {1'b1, 1'b0, 6'd0, er});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_drain"}, 16'(out_valid), 16'd0);
  endtask

  initial begin
    logic [W-1:0] er, eh, ra, rb;
    logic [4:0]   ef;
    logic [3:0]   rop;
    int           mlow;

    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b00101, "add_ff_01"};
    vecs[1]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 5'b01010, "add_ovf"};
    vecs[2]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b01000, "sub_ovf"};
    vecs[3]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 8'h00, 5'b00110, "sub_borrow"};
    vecs[4]  = '{4'd10, 8'h03, 8'h05, 8'h00, 8'h00, 5'b00100, "cmp_lt"};
    vecs[5]  = '{4'd10, 8'h05, 8'h05, 8'h00, 8'h00, 5'b00001, "cmp_eq"};
    vecs[6]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, "and"};
    vecs[7]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 8'h00, 5'b00010, "or"};
    vecs[8]  = '{4'd4,  8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00001, "xor"};
    vecs[9]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 8'h00, 5'b00010, "not"};
    vecs[10] = '{4'd6,  8'h81, 8'h01, 8'h02, 8'h00, 5'b00100, "shl_1"};
    vecs[11] = '{4'd7,  8'h81, 8'h00, 8'h81, 8'h00, 5'b00010, "shr_0"};
    vecs[12] = '{4'd7,  8'h01, 8'h01, 8'h00, 8'h00, 5'b00101, "shr_1"};
    vecs[13] = '{4'd8,  8'h90, 8'h02, 8'hE4, 8'h00, 5'b00010, "sra_2"};
    vecs[14] = '{4'd8,  8'h80, 8'h07, 8'hFF, 8'h00, 5'b00010, "sra_7"};
    vecs[15] = '{4'd8,  8'h40, 8'h07, 8'h00, 8'h00, 5'b00101, "sra_7_pos"};
    vecs[16] = '{4'd6,  8'h01, 8'h0F, 8'h80, 8'h00, 5'b00010, "shl_amt_mask"};
    vecs[17] = '{4'd9,  8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00010, "mul_ff_ff"};
    vecs[18] = '{4'd9,  8'h00, 8'h37, 8'h00, 8'h00, 5'b00001, "mul_zero"};
    vecs[19] = '{4'd9,  8'h10, 8'h10, 8'h00, 8'h01, 5'b00000, "mul_100"};
    vecs[20] = '{4'd11, 8'h12, 8'h5A, 8'h5A, 8'h00, 5'b00000, "pass"};
    vecs[21] = '{4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10000, "ill_f"};
    vecs[22] = '{4'd12, 8'h00, 8'h00, 8'h00, 8'h00, 5'b10000, "ill_c"};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    OPCODE = '0; OP1 = '0; OP2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {out_valid, in_ready, 1'b0, FLAGS, RESULT}, {1'b0, 1'b1, 14'd0});
    chk("reset_hi", 16'(RESULT_HI), 16'd0);
    rst = 1'b0;

    // Vector table
    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, vecs[i].r, vecs[i].h, vecs[i].f, vecs[i].nm);

    // Back-to-back SUB then CMP: out_valid stays high across both.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; OPCODE = 4'd1; OP1 = 8'h80; OP2 = 8'h01;
    @(negedge clk);
    chk("b2b_sub", {out_valid, 2'b00, FLAGS, RESULT}, {1'b1, 2'b00, 5'b01000, 8'h7F});
    OPCODE = 4'd10; OP1 = 8'h03; OP2 = 8'h05;
    @(negedge clk);
    chk("b2b_cmp", {out_valid, 2'b00, FLAGS, RESULT}, {1'b1, 2'b00, 5'b00100, 8'h00});
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", 16'(out_valid), 16'd0);

    // Backpressure: result held, in_ready low, held in_valid ignored.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; OPCODE = 4'd0; OP1 = 8'h12; OP2 = 8'h34;
    @(negedge clk);
    OPCODE = 4'd11; OP2 = 8'h77;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold", {out_valid, in_ready, 6'd0, RESULT}, {1'b1, 1'b0, 6'd0, 8'h46});
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {out_valid, 7'd0, RESULT}, {1'b0, 7'd0, 8'h46});

    // Reset 4 cycles into a MUL, with an op offered alongside the reset.
    @(negedge clk);
    in_valid = 1'b1; OPCODE = 4'd9; OP1 = 8'hFF; OP2 = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; OPCODE = 4'd0; OP1 = 8'h01; OP2 = 8'h01;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("mul_rst", {out_valid, in_ready, 1'b0, FLAGS, RESULT}, {1'b0, 1'b1, 14'd0});
    chk("mul_rst_hi", 16'(RESULT_HI), 16'd0);
    mlow = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (!out_valid && in_ready) mlow++;
    end
    chk("mul_rst_discard", 16'(mlow), 16'(W + 2));
    do_op(4'hF, 8'hAB, 8'hCD, 0, 8'h00, 8'h00, 5'b10000, "post_rst_ill");

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 8'($urandom); rb = 8'($urandom);
      ref_model(rop, ra, rb, er, eh, ef);
      do_op(rop, ra, rb, int'($urandom_range(0, 2)), er, eh, ef, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
